// File: rtl/pipe_stage_chain_pkg.sv
// pipe_pkg: control-bundle bit positions and sizing constants for the pipeline-register chain
package pipe_pkg;
    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMWRITE   = 1;
    localparam int CTRL_MEMREAD    = 2;
    localparam int CTRL_MEMTOREG   = 3;
    localparam int CTRL_JAL        = 4;
    localparam int CTRL_JUMP       = 5;
    localparam int CTRL_JR         = 6;
    localparam int CTRL_SAD        = 7;
    localparam int CTRL_MOVE       = 8;
    localparam int PIPE_CNT_W      = 16;
    localparam int PIPE_MAX_STAGES = 8;
endpackage

// File: rtl/pipe_stage_chain_slot.sv
// pipe_stage_slot: one elastic register slot; an empty slot always carries zero control
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int CTRL_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              next_free,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic              free
);
    assign free = !valid || next_free;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (Flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (free) begin
            valid <= in_valid;
            ctrl  <= in_valid ? in_ctrl : '0;
            if (in_valid) data <= in_data;
        end
    end
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/stall/flush register chain between execute sub-stages
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int CTRL_W = 16,
    parameter int STAGES = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  in_valid,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] stall_cnt,
    output logic [PIPE_CNT_W-1:0] flush_cnt
);
    // link k feeds slot k; link STAGES is the chain output
    logic              v [STAGES+1];
    logic [CTRL_W-1:0] c [STAGES+1];
    logic [DATA_W-1:0] d [STAGES+1];
    logic              f [STAGES+1];
    assign v[0]      = in_valid;
    assign c[0]      = in_ctrl;
    assign d[0]      = in_data;
    assign f[STAGES] = !Stall;
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
            .Clk       (Clk),
            .Reset     (Reset),
            .Flush     (Flush),
            .in_valid  (v[i]),
            .in_ctrl   (c[i]),
            .in_data   (d[i]),
            .next_free (f[i+1]),
            .valid     (v[i+1]),
            .ctrl      (c[i+1]),
            .data      (d[i+1]),
            .free      (f[i])
        );
    end
    assign in_ready  = f[0];
    assign out_valid = v[STAGES];
    assign out_ctrl  = c[STAGES];
    assign out_data  = d[STAGES];
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= (Stall && out_valid && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt <= (Flush && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end
endmodule
